line_sensor_filter: RTL

Front end of the line-following datapath. It samples the three raw reflective line sensors (left, middle, right) and synchronises them. It debounces each one with a saturating up/down integrator and hysteresis thresholds. It drives the filtered sensor bits consumed by the line-follow controller, plus a valid flag and a change strobe. Reset drives the output code to 3'b111 ("line lost"), so the controller stops the motors until real data arrives.

---
 rtl/line_follow_pkg.sv | 18 +
 rtl/sensor_channel_filter.sv | 64 ++++++
 rtl/line_sensor_filter.sv | 101 ++++++++++
 3 files changed

// File: rtl/line_follow_pkg.sv
// Shared constants for the line-follow datapath: sensor bit ordering,
// the "line lost" code and default filter tuning.
package line_follow_pkg;

    // Filtered code driven when no trustworthy data is available yet.
    localparam logic [2:0] SENSOR_LOST = 3'b111;

    // Bit positions in the {left, middle, right} code seen by the controller.
    localparam int unsigned IDX_L = 2;
    localparam int unsigned IDX_M = 1;
    localparam int unsigned IDX_R = 0;

    localparam int unsigned SAMPLE_DIV_DEFAULT = 50000;
    localparam int unsigned SAT_MAX_DEFAULT    = 15;
    localparam int unsigned TH_HI_DEFAULT      = 12;
    localparam int unsigned TH_LO_DEFAULT      = 3;

endpackage

// File: rtl/sensor_channel_filter.sv
// One sensor channel: 2-flop synchroniser, saturating up/down integrator
// and hysteresis output bit.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   tick        sample strike; integrator moves only when high
//   raw         asynchronous raw sensor level
//   filtered    debounced sensor level (registered)
module sensor_channel_filter
    import line_follow_pkg::*;
#(
    parameter int unsigned SAT_MAX = SAT_MAX_DEFAULT,
    parameter int unsigned TH_HI   = TH_HI_DEFAULT,
    parameter int unsigned TH_LO   = TH_LO_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic raw,
    output logic filtered
);

    localparam int unsigned CNT_W = $clog2(SAT_MAX + 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] integ_q, integ_d;
    logic             filt_q, filt_d;
    logic             synced;

    assign synced   = sync_q[1];
    assign filtered = filt_q;

    // Synchroniser runs every cycle; integrator and output advance via _d.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            integ_q <= CNT_W'(SAT_MAX);
            filt_q  <= 1'b1;
        end else begin
            sync_q  <= {sync_q[0], raw};
            integ_q <= integ_d;
            filt_q  <= filt_d;
        end
    end

    // Output decision uses the integrator's next value so the bit flips
    // on the same edge the threshold is crossed.
    always_comb begin
        integ_d = integ_q;
        filt_d  = filt_q;
        if (tick) begin
            if (synced && (integ_q < CNT_W'(SAT_MAX))) begin
                integ_d = integ_q + CNT_W'(1);
            end else if (!synced && (integ_q != '0)) begin
                integ_d = integ_q - CNT_W'(1);
            end
            if (integ_d >= CNT_W'(TH_HI)) begin
                filt_d = 1'b1;
            end else if (integ_d <= CNT_W'(TH_LO)) begin
                filt_d = 1'b0;
            end
        end
    end

endmodule

// File: rtl/line_sensor_filter.sv
// Line sensor front end: sample prescaler, three debounce channels,
// sticky valid flag and a one-cycle change strobe on the filtered code.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   enable                     1 = filter runs, 0 = prescaler/integrators frozen
//   sensor{Left,Middle,Right}Raw       asynchronous raw sensors
//   sensor{Left,Middle,Right}Filtered  debounced sensors (reset to 1)
//   sensorsValid               sticky, set once SAT_MAX ticks have elapsed
//   sensorsChanged             one-cycle pulse after the filtered code changes
module line_sensor_filter
    import line_follow_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = SAMPLE_DIV_DEFAULT,
    parameter int unsigned SAT_MAX    = SAT_MAX_DEFAULT,
    parameter int unsigned TH_HI      = TH_HI_DEFAULT,
    parameter int unsigned TH_LO      = TH_LO_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic sensorLeftRaw,
    input  logic sensorMiddleRaw,
    input  logic sensorRightRaw,
    output logic sensorLeftFiltered,
    output logic sensorMiddleFiltered,
    output logic sensorRightFiltered,
    output logic sensorsValid,
    output logic sensorsChanged
);

    localparam int unsigned CNT_W   = $clog2(SAT_MAX + 1);
    localparam int unsigned PRESC_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic               valid_q, valid_d;
    logic [2:0]         code_prev_q, code_prev_d;
    logic               changed_q, changed_d;
    logic               tick_c;
    logic [2:0]         raw_vec;
    logic [2:0]         filt_code;

    assign raw_vec[IDX_L] = sensorLeftRaw;
    assign raw_vec[IDX_M] = sensorMiddleRaw;
    assign raw_vec[IDX_R] = sensorRightRaw;

    // Tick only while enabled; a frozen prescaler never strikes.
    assign tick_c = enable && (presc_q == PRESC_W'(SAMPLE_DIV - 1));

    for (genvar g = 0; g < 3; g++) begin : g_chan
        sensor_channel_filter #(
            .SAT_MAX (SAT_MAX),
            .TH_HI   (TH_HI),
            .TH_LO   (TH_LO)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .tick     (tick_c),
            .raw      (raw_vec[g]),
            .filtered (filt_code[g])
        );
    end

    assign sensorLeftFiltered   = filt_code[IDX_L];
    assign sensorMiddleFiltered = filt_code[IDX_M];
    assign sensorRightFiltered  = filt_code[IDX_R];
    assign sensorsValid         = valid_q;
    assign sensorsChanged       = changed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q     <= '0;
            tick_cnt_q  <= '0;
            valid_q     <= 1'b0;
            code_prev_q <= SENSOR_LOST;
            changed_q   <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            tick_cnt_q  <= tick_cnt_d;
            valid_q     <= valid_d;
            code_prev_q <= code_prev_d;
            changed_q   <= changed_d;
        end
    end

    // Prescaler wrap, saturating tick counter and change detection.
    always_comb begin
        presc_d     = presc_q;
        tick_cnt_d  = tick_cnt_q;
        if (enable) begin
            presc_d = tick_c ? '0 : presc_q + PRESC_W'(1);
        end
        if (tick_c && (tick_cnt_q != CNT_W'(SAT_MAX))) begin
            tick_cnt_d = tick_cnt_q + CNT_W'(1);
        end
        valid_d     = valid_q | (tick_cnt_d == CNT_W'(SAT_MAX));
        code_prev_d = filt_code;
        changed_d   = (filt_code != code_prev_q);
    end

endmodule
